// File: rtl/spi_command_port.sv
// SPI mode-0 slave front end for the DSP engine command interface.
// Deserialises MOSI into command bytes, returns the engine status byte on MISO, guards the command FIFO.
//   state | meaning
//   IDLE  | deselected, MISO held low, SCK ignored
//   FRAME | CS low, shifting bytes in on SCK rise and out on SCK fall
module spi_command_port #(
    parameter int spi_fifo_length = 32,
    parameter int sync_stages     = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               spi_sck,
    input  logic                               spi_cs_n,
    input  logic                               spi_mosi,
    output logic                               spi_miso,
    output logic [7:0]                         command_out,
    output logic                               command_out_valid,
    input  logic [$clog2(spi_fifo_length):0]   fifo_count,
    input  logic [7:0]                         tx_byte,
    output logic                               frame_active,
    output logic                               overrun,
    input  logic                               overrun_clear
);

    localparam int CW = $clog2(spi_fifo_length) + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(spi_fifo_length);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                 state_q;
    logic [sync_stages-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, flush_q;
    logic                   sck_prev_q, cs_prev_q, armed_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             rx_q, tx_q, cmd_q;
    logic                   byte_done_q, skip_shift_q;
    logic                   miso_q, valid_q, frame_q, overrun_q;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_s    = sck_sync_q[sync_stages-1];
    assign cs_s     = cs_sync_q[sync_stages-1];
    assign mosi_s   = mosi_sync_q[sync_stages-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sck_sync_q   <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            flush_q      <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 8'h00;
            tx_q         <= 8'h00;
            cmd_q        <= 8'h00;
            byte_done_q  <= 1'b0;
            skip_shift_q <= 1'b0;
            miso_q       <= 1'b0;
            valid_q      <= 1'b0;
            frame_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[sync_stages-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[sync_stages-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[sync_stages-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            // A CS already low when reset releases must not open a frame; wait to see it high first.
            flush_q     <= {flush_q[sync_stages-2:0], 1'b1};
            if (flush_q[sync_stages-1] && cs_s)
                armed_q <= 1'b1;

            valid_q <= 1'b0;
            miso_q  <= (state_q == FRAME) ? tx_q[7] : 1'b0;

            if (overrun_clear)
                overrun_q <= 1'b0;

            if (byte_done_q) begin
                byte_done_q <= 1'b0;
                if (fifo_count < FIFO_FULL) begin
                    cmd_q   <= rx_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
                tx_q         <= tx_byte;
                // The fall that follows the 8th rise must present the new bit 7, not shift it away.
                skip_shift_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_q      <= FRAME;
                        bit_cnt_q    <= 3'd0;
                        rx_q         <= 8'h00;
                        tx_q         <= tx_byte;
                        skip_shift_q <= 1'b0;
                        frame_q      <= 1'b1;
                    end
                end
                FRAME: begin
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= 3'd0;
                        miso_q    <= 1'b0;
                        frame_q   <= 1'b0;
                    end else begin
                        if (sck_rise) begin
                            rx_q      <= {rx_q[6:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7)
                                byte_done_q <= 1'b1;
                        end
                        if (sck_fall) begin
                            if (skip_shift_q)
                                skip_shift_q <= 1'b0;
                            else
                                tx_q <= {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_miso          = miso_q;
    assign command_out       = cmd_q;
    assign command_out_valid = valid_q;
    assign frame_active      = frame_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_spi_command_port.sv
// Directed bench for spi_command_port: scoreboarded command strobes, MISO readback, overrun and reset cases.
module tb_spi_command_port;

    logic       clk = 1'b0;
    logic       reset_n, spi_sck, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0] command_out, tx_byte;
    logic       command_out_valid, frame_active, overrun, overrun_clear;
    logic [5:0] fifo_count;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    logic [7:0] rb1, rb2, rbx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_command_port dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .spi_sck           (spi_sck),
        .spi_cs_n          (spi_cs_n),
        .spi_mosi          (spi_mosi),
        .spi_miso          (spi_miso),
        .command_out       (command_out),
        .command_out_valid (command_out_valid),
        .fifo_count        (fifo_count),
        .tx_byte           (tx_byte),
        .frame_active      (frame_active),
        .overrun           (overrun),
        .overrun_clear     (overrun_clear)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every strobe must match the oldest expected byte, arrive on its predicted cycle and last one cycle.
    always @(negedge clk) begin
        if (command_out_valid) begin
            check("strobe_width", {31'b0, prev_valid}, 32'd0);
            check("strobe_expected", {31'b0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("cmd_byte", {24'b0, command_out}, {24'b0, mon_e.b});
                check("strobe_latency", cyc, mon_e.c);
            end
        end
        prev_valid = command_out_valid;
    end

    task automatic spi_byte(input logic [7:0] b, input int nbits, input bit expect_rx,
                            input bit clr_at_drop, output logic [7:0] rb);
        rb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            repeat (4) @(negedge clk);
            rb[7-i] = spi_miso;
            spi_sck = 1'b1;
            if (i == 7 && expect_rx) sb.push_back('{b, cyc + 4});
            if (i == 7 && clr_at_drop) begin
                repeat (3) @(negedge clk);
                overrun_clear = 1'b1;
                @(negedge clk);
                overrun_clear = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check(tag, sb.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, {31'b0, spi_miso}, 32'd0);
        check({tag, "_cmd"}, {24'b0, command_out}, 32'h00);
        check({tag, "_valid"}, {31'b0, command_out_valid}, 32'd0);
        check({tag, "_frame"}, {31'b0, frame_active}, 32'd0);
        check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        fifo_count = 6'd0; tx_byte = 8'h00; overrun_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // single byte
        cs_low();
        check("frame_up", {31'b0, frame_active}, 32'd1);
        spi_byte(8'hA5, 8, 1'b1, 1'b0, rbx);
        cs_high();
        check("frame_down", {31'b0, frame_active}, 32'd0);
        drain("drain_single");

        // two-byte frame with readback
        tx_byte = 8'h3C;
        cs_low();
        tx_byte = 8'hC3;
        spi_byte(8'h01, 8, 1'b1, 1'b0, rb1);
        spi_byte(8'h02, 8, 1'b1, 1'b0, rb2);
        cs_high();
        check("miso_byte0", {24'b0, rb1}, 32'h3C);
        check("miso_byte1", {24'b0, rb2}, 32'hC3);
        check("miso_idle", {31'b0, spi_miso}, 32'd0);
        drain("drain_two");

        // aborted byte, then a clean frame
        cs_low();
        spi_byte(8'hFF, 5, 1'b0, 1'b0, rbx);
        cs_high();
        check("abort_frame_down", {31'b0, frame_active}, 32'd0);
        cs_low();
        spi_byte(8'h11, 8, 1'b1, 1'b0, rbx);
        cs_high();
        drain("drain_abort");

        // FIFO full, overrun set/clear priority, boundary just below full
        fifo_count = 6'd32;
        cs_low();
        spi_byte(8'h55, 8, 1'b0, 1'b0, rbx);
        repeat (6) @(negedge clk);
        check("overrun_set", {31'b0, overrun}, 32'd1);
        spi_byte(8'hAA, 8, 1'b0, 1'b1, rbx);
        repeat (2) @(negedge clk);
        check("overrun_set_wins", {31'b0, overrun}, 32'd1);
        overrun_clear = 1'b1;
        @(negedge clk);
        overrun_clear = 1'b0;
        @(negedge clk);
        check("overrun_cleared", {31'b0, overrun}, 32'd0);
        fifo_count = 6'd31;
        spi_byte(8'h66, 8, 1'b1, 1'b0, rbx);
        repeat (6) @(negedge clk);
        check("no_overrun_at_31", {31'b0, overrun}, 32'd0);
        fifo_count = 6'd32;
        spi_byte(8'h99, 8, 1'b0, 1'b0, rbx);
        cs_high();
        check("overrun_again", {31'b0, overrun}, 32'd1);
        fifo_count = 6'd0;
        drain("drain_fifo");

        // reset mid-frame
        cs_low();
        spi_byte(8'hF0, 4, 1'b0, 1'b0, rbx);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_values("midrst");
        spi_byte(8'hC3, 8, 1'b0, 1'b0, rbx);
        repeat (6) @(negedge clk);
        check("midrst_still_idle", {31'b0, frame_active}, 32'd0);
        cs_high();
        cs_low();
        check("midrst_reframe", {31'b0, frame_active}, 32'd1);
        spi_byte(8'h7E, 8, 1'b1, 1'b0, rbx);
        cs_high();
        drain("drain_reset");

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_command_port.md
# spi_command_port

SPI mode-0 slave front end that feeds the DSP engine's command interface. It deserialises MOSI into bytes and presents each completed byte to the engine as a one-cycle `command_in`/`command_in_valid` strobe. In the same frame it serialises the engine's `spi_byte_out` status byte back on MISO. It also guards the engine's command FIFO against overflow by using the engine's `fifo_count`.

## Interface
- `spi_fifo_length`, default 32: depth of the engine command FIFO; sets the `fifo_count` width and the full threshold.
- `sync_stages`, default 2: synchroniser flops on `spi_sck`, `spi_cs_n` and `spi_mosi` (minimum 2).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `spi_sck`  in  1  SPI clock, asynchronous to `clk`, idle low.
- `spi_cs_n`  in  1  chip select, active low, asynchronous.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first; held low while deselected.
- `command_out`  out  8  completed byte, wired to the engine's `command_in`.
- `command_out_valid`  out  1  one-cycle strobe, wired to the engine's `command_in_valid`.
- `fifo_count`  in  $clog2(spi_fifo_length)+1  current occupancy of the engine command FIFO.
- `tx_byte`  in  8  byte to return, wired to the engine's `spi_byte_out`.
- `frame_active`  out  1  high while the synchronised CS is low.
- `overrun`  out  1  sticky: at least one byte was dropped because the FIFO was full.
- `overrun_clear`  in  1  one-cycle pulse that clears `overrun`.

## Operation
- All three SPI inputs pass through `sync_stages` flops. Edges are detected by comparing the last synchronised value with a registered copy of it.
- The FSM has two states:
  - **IDLE** → **FRAME** on the synchronised CS falling edge. On entry: bit counter = 0, rx shift register = 0, tx shift register ← `tx_byte`, `frame_active` = 1.
  - **FRAME** → **IDLE** on the synchronised CS rising edge. On exit: bit counter = 0, `spi_miso` = 0, `frame_active` = 0. Any partial byte is discarded and no strobe is issued.
- In FRAME, on each synchronised SCK rising edge:
  - rx ← {rx[6:0], mosi_sync};
  - the bit counter increments (3 bits, so it wraps 7→0).
- When the counter wraps, the byte is complete:
  - If `fifo_count < spi_fifo_length`: `command_out` ← the assembled byte and `command_out_valid` = 1 for exactly one clk.
  - Otherwise the byte is dropped, no strobe is issued, and `overrun` is set.
  - In either case tx ← `tx_byte`, sampled in that same cycle. Back-to-back bytes in one frame are supported.
- In FRAME, on each synchronised SCK falling edge: tx ← {tx[6:0], 0}. `spi_miso` always reflects tx[7] while in FRAME.
- `overrun` is set by a dropped byte and cleared by `overrun_clear`. If both occur in the same cycle, the set wins.
- SCK edges while in IDLE are ignored.
- A CS falling edge and an SCK edge landing in the same synchronised cycle: the CS edge is processed and the SCK edge is ignored.
- Reset (`reset_n` low at a `clk` edge) has priority over everything, including mid-frame. The block returns to IDLE and all outputs take their reset values. The block re-enters FRAME only on a fresh CS falling edge after reset is released.

## Timing
- Reset values:
  - `spi_miso` = 0, `command_out` = 8'h00, `command_out_valid` = 0, `frame_active` = 0, `overrun` = 0;
  - synchronisers = CS high, SCK low, MOSI 0.
- Supported SCK frequency: at most clk/8. Both SCK high time and SCK low time must each be at least 4 clk periods.
- Latencies, measured from the first `clk` edge that captures the raw 8th SCK rise:
  - `command_out_valid` rises `sync_stages`+1 cycles later, i.e. 3 cycles with the defaults.
  - `command_out` is stable in the cycle of the strobe and holds its value until the next strobe.
- MISO: `spi_miso` updates `sync_stages`+1 cycles after the first `clk` edge that captures the raw SCK fall.
  - For bit 7 of the first byte, the reference point is the CS fall instead.
  - The master must allow at least half an SCK period before sampling MISO.
- The `fifo_count` threshold is evaluated in the completion cycle, using the registered value.

## Test plan
- **Single byte.** Reset, drive CS low, shift 8'hA5 at clk/8, raise CS.
  - `command_out_valid` pulses exactly once, for 1 cycle, with `command_out` = 8'hA5, 3 cycles after the 8th SCK rise.
- **Two-byte frame with readback.** `tx_byte` = 8'h3C at CS fall, then 8'hC3. Shift 8'h01 then 8'h02.
  - Two strobes with 8'h01 and 8'h02.
  - The master samples MISO as 8'h3C then 8'hC3.
- **Aborted byte.** CS rises after 5 bits of 8'hFF.
  - No strobe; `frame_active` falls.
  - The next frame, 8'h11, is received as 8'h11 with no leftover bits.
- **FIFO full.** `fifo_count` = 32, then send 8'h55.
  - No strobe and `overrun` = 1.
  - Pulse `overrun_clear` together with another dropped byte: `overrun` stays 1.
  - Pulse `overrun_clear` alone: `overrun` = 0.
- **Reset mid-frame.** Pull `reset_n` low for 1 cycle after 4 bits while CS stays low.
  - All outputs return to reset values.
  - Remaining SCK edges produce no strobe until CS toggles high then low again.
  - A subsequent 8'h7E is received correctly.
